// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state encoding, bank field position and error data for bus_fabric
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int          BANK_HI  = 31;
    localparam int          BANK_LO  = 24;
    localparam int          IDX_W    = 3;
    localparam logic [31:0] ERR_DATA = 32'h0000_0000;

    function automatic logic [7:0] bank_of(input logic [31:0] adr);
        return adr[BANK_HI:BANK_LO];
    endfunction

endpackage

// File: rtl/bus_decode.sv
// rtl/bus_decode.sv - combinational bank decode: address bank field to slave hit and index
module bus_decode
    import bus_pkg::*;
#(
    parameter int                     NSLAVES     = 4,
    parameter logic [8*NSLAVES-1:0]   SLAVE_BANKS = {8'h04, 8'h03, 8'h02, 8'h00}
) (
    input  logic [31:0]      adr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scan downward so the lowest matching slave is the last to overwrite.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (SLAVE_BANKS[i*8 +: 8] == bank_of(adr)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// rtl/bus_fabric.sv - single-master bank-decoded bus fabric with timeout and sticky error address
module bus_fabric
    import bus_pkg::*;
#(
    parameter int                     NSLAVES     = 4,
    parameter logic [8*NSLAVES-1:0]   SLAVE_BANKS = {8'h04, 8'h03, 8'h02, 8'h00},
    parameter int                     TIMEOUT     = 255
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    m_stb_i,
    input  logic                    m_we_i,
    input  logic [31:0]             m_adr_i,
    input  logic [3:0]              m_sel_i,
    input  logic [31:0]             m_dat_i,
    output logic [31:0]             m_dat_o,
    output logic                    m_ack_o,
    output logic                    m_err_o,
    output logic [NSLAVES-1:0]      s_stb_o,
    output logic                    s_we_o,
    output logic [31:0]             s_adr_o,
    output logic [3:0]              s_sel_o,
    output logic [31:0]             s_dat_o,
    input  logic [NSLAVES-1:0]      s_ack_i,
    input  logic [32*NSLAVES-1:0]   s_dat_i,
    output logic [31:0]             err_adr_o
);

    localparam int               CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    state_t             state, state_nxt;
    logic               dec_hit;
    logic [IDX_W-1:0]   dec_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic [NSLAVES-1:0] dec_onehot;
    logic [31:0]        sel_dat;
    logic               sel_ack;
    logic               ack_hit;
    logic               timed_out;
    logic               err_flag;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;

    bus_decode #(
        .NSLAVES     (NSLAVES),
        .SLAVE_BANKS (SLAVE_BANKS)
    ) u_decode (
        .adr (m_adr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    // s_stb_o is one-hot on the selected slave while BUSY, so it doubles as the ack mask.
    always_comb begin
        dec_onehot = '0;
        sel_dat    = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            dec_onehot[i] = (dec_idx == IDX_W'(i));
            if (sel_idx == IDX_W'(i)) begin
                sel_dat = s_dat_i[i*32 +: 32];
            end
        end
        sel_ack   = |(s_ack_i & s_stb_o);
        cnt_inc   = cnt + CNT_W'(1);
        ack_hit   = (state == ST_BUSY) && sel_ack;
        timed_out = (state == ST_BUSY) && !sel_ack && (cnt_inc == TO_VAL);
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (m_stb_i) state_nxt = dec_hit ? ST_BUSY : ST_RESP;
            ST_BUSY: if (ack_hit || timed_out) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_HOLD;
            ST_HOLD: if (!m_stb_i) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            s_stb_o   <= '0;
            s_we_o    <= 1'b0;
            s_adr_o   <= '0;
            s_sel_o   <= '0;
            s_dat_o   <= '0;
            m_dat_o   <= '0;
            m_ack_o   <= 1'b0;
            m_err_o   <= 1'b0;
            err_adr_o <= '0;
            sel_idx   <= '0;
            err_flag  <= 1'b0;
            cnt       <= '0;
        end else begin
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (m_stb_i) begin
                        s_we_o   <= m_we_i;
                        s_adr_o  <= m_adr_i;
                        s_sel_o  <= m_sel_i;
                        s_dat_o  <= m_dat_i;
                        sel_idx  <= dec_idx;
                        err_flag <= !dec_hit;
                        cnt      <= '0;
                        if (dec_hit) begin
                            s_stb_o <= dec_onehot;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt_inc;
                    if (ack_hit) begin
                        s_stb_o  <= '0;
                        m_dat_o  <= sel_dat;
                        err_flag <= 1'b0;
                    end else if (timed_out) begin
                        s_stb_o  <= '0;
                        m_dat_o  <= ERR_DATA;
                        err_flag <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (err_flag) begin
                        m_err_o   <= 1'b1;
                        err_adr_o <= s_adr_o;
                    end else begin
                        m_ack_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
